// File: rtl/oursring_req_mux2.sv
// 2:1 merger for the oursring request interface: AR arbitrated per beat,
// AW+W arbitrated per write burst and locked to the owner until wlast.
package oursring_pkg;
    typedef struct packed {
        logic [3:0]  awid;
        logic [39:0] awaddr;
        logic [7:0]  awlen;
    } oursring_req_if_aw_t;

    typedef struct packed {
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        wlast;
    } oursring_req_if_w_t;

    typedef struct packed {
        logic [3:0]  arid;
        logic [39:0] araddr;
        logic [7:0]  arlen;
    } oursring_req_if_ar_t;
endpackage

module oursring_req_mux2
    import oursring_pkg::*;
#(
    parameter int RR_EN      = 1,
    parameter int MAX_WBEATS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  oursring_req_if_aw_t s0_req_if_aw,
    input  logic                s0_req_if_awvalid,
    output logic                s0_req_if_awready,
    input  oursring_req_if_w_t  s0_req_if_w,
    input  logic                s0_req_if_wvalid,
    output logic                s0_req_if_wready,
    input  oursring_req_if_ar_t s0_req_if_ar,
    input  logic                s0_req_if_arvalid,
    output logic                s0_req_if_arready,
    input  oursring_req_if_aw_t s1_req_if_aw,
    input  logic                s1_req_if_awvalid,
    output logic                s1_req_if_awready,
    input  oursring_req_if_w_t  s1_req_if_w,
    input  logic                s1_req_if_wvalid,
    output logic                s1_req_if_wready,
    input  oursring_req_if_ar_t s1_req_if_ar,
    input  logic                s1_req_if_arvalid,
    output logic                s1_req_if_arready,
    output oursring_req_if_aw_t m_req_if_aw,
    output logic                m_req_if_awvalid,
    input  logic                m_req_if_awready,
    output oursring_req_if_w_t  m_req_if_w,
    output logic                m_req_if_wvalid,
    input  logic                m_req_if_wready,
    output oursring_req_if_ar_t m_req_if_ar,
    output logic                m_req_if_arvalid,
    input  logic                m_req_if_arready,
    output logic                o_wr_busy,
    output logic                o_wlen_err
);
    localparam int CW = $clog2(MAX_WBEATS + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WBEATS);
    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_DATA = 1'b1;

    logic          ar_ptr_q, ar_ptr_d, ar_hold_q, ar_hold_d, ar_gnt_q, ar_gnt_d, ar_gnt;
    logic          wr_ptr_q, wr_ptr_d, aw_hold_q, aw_hold_d, aw_gnt_q, aw_gnt_d, aw_gnt;
    logic          owner_q, owner_d, wlen_err_q, wlen_err_d;
    logic [0:0]    state_q, state_d;
    logic [CW-1:0] beat_cnt_q, beat_cnt_d, beat_nxt;
    logic          in_idle, in_data, aw_hs, w_hs;

    // A stalled grant is replayed from the flops so a late-arriving
    // competitor cannot steal the port mid-handshake.
    always_comb begin
        if (ar_hold_q)
            ar_gnt = ar_gnt_q;
        else if (s0_req_if_arvalid && s1_req_if_arvalid)
            ar_gnt = (RR_EN != 0) ? ar_ptr_q : 1'b0;
        else
            ar_gnt = s1_req_if_arvalid;

        m_req_if_ar       = ar_gnt ? s1_req_if_ar : s0_req_if_ar;
        m_req_if_arvalid  = !rst && (ar_gnt ? s1_req_if_arvalid : s0_req_if_arvalid);
        s0_req_if_arready = !rst && !ar_gnt && s0_req_if_arvalid && m_req_if_arready;
        s1_req_if_arready = !rst &&  ar_gnt && s1_req_if_arvalid && m_req_if_arready;

        ar_hold_d = m_req_if_arvalid && !m_req_if_arready;
        ar_gnt_d  = ar_gnt;
        ar_ptr_d  = (m_req_if_arvalid && m_req_if_arready) ? !ar_gnt : ar_ptr_q;
    end

    always_comb begin
        in_idle = (state_q == W_IDLE);
        in_data = (state_q == W_DATA);

        if (aw_hold_q)
            aw_gnt = aw_gnt_q;
        else if (s0_req_if_awvalid && s1_req_if_awvalid)
            aw_gnt = (RR_EN != 0) ? wr_ptr_q : 1'b0;
        else
            aw_gnt = s1_req_if_awvalid;

        m_req_if_aw       = aw_gnt ? s1_req_if_aw : s0_req_if_aw;
        m_req_if_awvalid  = !rst && in_idle && (aw_gnt ? s1_req_if_awvalid : s0_req_if_awvalid);
        s0_req_if_awready = !rst && in_idle && !aw_gnt && s0_req_if_awvalid && m_req_if_awready;
        s1_req_if_awready = !rst && in_idle &&  aw_gnt && s1_req_if_awvalid && m_req_if_awready;

        m_req_if_w        = owner_q ? s1_req_if_w : s0_req_if_w;
        m_req_if_wvalid   = !rst && in_data && (owner_q ? s1_req_if_wvalid : s0_req_if_wvalid);
        s0_req_if_wready  = !rst && in_data && !owner_q && m_req_if_wready;
        s1_req_if_wready  = !rst && in_data &&  owner_q && m_req_if_wready;

        aw_hs    = m_req_if_awvalid && m_req_if_awready;
        w_hs     = m_req_if_wvalid && m_req_if_wready;
        beat_nxt = beat_cnt_q + CW'(1);

        aw_hold_d  = m_req_if_awvalid && !m_req_if_awready;
        aw_gnt_d   = aw_gnt;
        state_d    = state_q;
        owner_d    = owner_q;
        wr_ptr_d   = wr_ptr_q;
        beat_cnt_d = beat_cnt_q;
        wlen_err_d = 1'b0;

        if (aw_hs) begin
            state_d    = W_DATA;
            owner_d    = aw_gnt;
            beat_cnt_d = '0;
        end
        if (w_hs) begin
            beat_cnt_d = (beat_cnt_q == MAX_CNT) ? MAX_CNT : beat_nxt;
            if (m_req_if_w.wlast) begin
                state_d  = W_IDLE;
                wr_ptr_d = !owner_q;
            end else if (beat_nxt == MAX_CNT) begin
                wlen_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_ptr_q   <= 1'b0;
            ar_hold_q  <= 1'b0;
            ar_gnt_q   <= 1'b0;
            wr_ptr_q   <= 1'b0;
            aw_hold_q  <= 1'b0;
            aw_gnt_q   <= 1'b0;
            owner_q    <= 1'b0;
            state_q    <= W_IDLE;
            beat_cnt_q <= '0;
            wlen_err_q <= 1'b0;
        end else begin
            ar_ptr_q   <= ar_ptr_d;
            ar_hold_q  <= ar_hold_d;
            ar_gnt_q   <= ar_gnt_d;
            wr_ptr_q   <= wr_ptr_d;
            aw_hold_q  <= aw_hold_d;
            aw_gnt_q   <= aw_gnt_d;
            owner_q    <= owner_d;
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            wlen_err_q <= wlen_err_d;
        end
    end

    assign o_wr_busy  = (state_q == W_DATA);
    assign o_wlen_err = wlen_err_q;
endmodule

// File: tb/tb_oursring_req_mux2.sv
// Bench for oursring_req_mux2: instance 0 is round-robin with MAX_WBEATS=4,
// instance 1 is fixed priority with MAX_WBEATS=16; both share the inputs.
module tb_oursring_req_mux2;
    import oursring_pkg::*;

    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    oursring_req_if_aw_t s_aw [2];
    oursring_req_if_w_t  s_w  [2];
    oursring_req_if_ar_t s_ar [2];
    logic s_awvalid [2];
    logic s_wvalid  [2];
    logic s_arvalid [2];
    logic m_awready, m_wready, m_arready;

    logic [1:0] o_awready [2];
    logic [1:0] o_wready  [2];
    logic [1:0] o_arready [2];
    oursring_req_if_aw_t o_m_aw [2];
    oursring_req_if_w_t  o_m_w  [2];
    oursring_req_if_ar_t o_m_ar [2];
    logic o_m_awvalid [2];
    logic o_m_wvalid  [2];
    logic o_m_arvalid [2];
    logic o_busy [2];
    logic o_err  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        oursring_req_mux2 #(.RR_EN(g == 0 ? 1 : 0), .MAX_WBEATS(g == 0 ? MAXB : 16)) u_dut (
            .clk(clk), .rst(rst),
            .s0_req_if_aw(s_aw[0]), .s0_req_if_awvalid(s_awvalid[0]), .s0_req_if_awready(o_awready[g][0]),
            .s0_req_if_w(s_w[0]),   .s0_req_if_wvalid(s_wvalid[0]),   .s0_req_if_wready(o_wready[g][0]),
            .s0_req_if_ar(s_ar[0]), .s0_req_if_arvalid(s_arvalid[0]), .s0_req_if_arready(o_arready[g][0]),
            .s1_req_if_aw(s_aw[1]), .s1_req_if_awvalid(s_awvalid[1]), .s1_req_if_awready(o_awready[g][1]),
            .s1_req_if_w(s_w[1]),   .s1_req_if_wvalid(s_wvalid[1]),   .s1_req_if_wready(o_wready[g][1]),
            .s1_req_if_ar(s_ar[1]), .s1_req_if_arvalid(s_arvalid[1]), .s1_req_if_arready(o_arready[g][1]),
            .m_req_if_aw(o_m_aw[g]), .m_req_if_awvalid(o_m_awvalid[g]), .m_req_if_awready(m_awready),
            .m_req_if_w(o_m_w[g]),   .m_req_if_wvalid(o_m_wvalid[g]),   .m_req_if_wready(m_wready),
            .m_req_if_ar(o_m_ar[g]), .m_req_if_arvalid(o_m_arvalid[g]), .m_req_if_arready(m_arready),
            .o_wr_busy(o_busy[g]), .o_wlen_err(o_err[g])
        );
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    function automatic oursring_req_if_ar_t mk_ar(input logic [39:0] a, input int id);
        oursring_req_if_ar_t r;
        r.arid = 4'(id); r.araddr = a; r.arlen = 8'd0;
        return r;
    endfunction

    function automatic oursring_req_if_aw_t mk_aw(input logic [39:0] a, input int id);
        oursring_req_if_aw_t r;
        r.awid = 4'(id); r.awaddr = a; r.awlen = 8'd0;
        return r;
    endfunction

    function automatic oursring_req_if_w_t mk_w(input int s, input int id, input int b, input bit last);
        oursring_req_if_w_t r;
        r.wdata = {32'(s), 16'(id), 16'(b)}; r.wstrb = 8'hFF; r.wlast = last;
        return r;
    endfunction

    // Expected winner under the spec's arbitration rule: -1 means none.
    function automatic int pick(input int hold, input int pref, input logic v0, input logic v1);
        if (hold >= 0) return hold;
        if (v0 && v1)  return pref;
        if (v1)        return 1;
        if (v0)        return 0;
        return -1;
    endfunction

    function automatic logic [1:0] rmask(input int e, input logic r);
        if (e < 0 || !r) return 2'b00;
        return (e == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_valids();
        for (int s = 0; s < 2; s++) begin
            s_awvalid[s] = 1'b0; s_wvalid[s] = 1'b0; s_arvalid[s] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int ar_pref, ar_hold, aw_pref, aw_hold, busy, owner, nbeats, e;
    bit err_exp, err_next;
    int has_burst [2], bl_len [2], bl_sent [2], bl_id [2];
    bit drop_ar [2], drop_aw [2], drop_w [2];
    logic mwr;

    initial begin
        rst = 1'b1;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        for (int s = 0; s < 2; s++) begin
            s_aw[s] = mk_aw(40'h0, s); s_w[s] = mk_w(s, 0, 0, 1'b0); s_ar[s] = mk_ar(40'h0, s);
            s_awvalid[s] = 1'b1; s_wvalid[s] = 1'b1; s_arvalid[s] = 1'b1;
        end
        nxt(); nxt();
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chkv("rst_readies", 128'({o_arready[g], o_awready[g], o_wready[g]}), 128'(0));
            chkv("rst_m_valids", 128'({o_m_arvalid[g], o_m_awvalid[g], o_m_wvalid[g]}), 128'(0));
            chk1("rst_busy", o_busy[g], 1'b0);
            chk1("rst_err", o_err[g], 1'b0);
        end

        // AR: both valid in the first cycle after reset
        nxt(); rst = 1'b0; clear_valids();
        s_ar[0] = mk_ar(40'h100, 0); s_ar[1] = mk_ar(40'h200, 1);
        s_arvalid[0] = 1'b1; s_arvalid[1] = 1'b1;
        @(negedge clk);
        chkv("ar1_c1_m_ar", 128'(o_m_ar[0]), 128'(mk_ar(40'h100, 0)));
        chk1("ar1_c1_valid", o_m_arvalid[0], 1'b1);
        chkv("ar1_c1_ready", 128'(o_arready[0]), 128'(2'b01));
        nxt(); s_arvalid[0] = 1'b0;
        @(negedge clk);
        chkv("ar1_c2_m_ar", 128'(o_m_ar[0]), 128'(mk_ar(40'h200, 1)));
        chkv("ar1_c2_ready", 128'(o_arready[0]), 128'(2'b10));
        nxt(); s_arvalid[1] = 1'b0;
        @(negedge clk);
        chkv("ar1_c3_ready", 128'(o_arready[0]), 128'(2'b00));
        chk1("ar1_c3_valid", o_m_arvalid[0], 1'b0);

        // AR backpressure with both valid: s0 (pointer back at s0) held 5 cycles
        nxt();
        s_ar[0] = mk_ar(40'h300, 0); s_ar[1] = mk_ar(40'h400, 1);
        s_arvalid[0] = 1'b1; s_arvalid[1] = 1'b1; m_arready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chkv("ar_bp_m_ar", 128'(o_m_ar[0]), 128'(mk_ar(40'h300, 0)));
            chk1("ar_bp_valid", o_m_arvalid[0], 1'b1);
            chkv("ar_bp_ready", 128'(o_arready[0]), 128'(2'b00));
            nxt();
        end
        m_arready = 1'b1;
        @(negedge clk);
        chkv("ar_bp_rel_ready", 128'(o_arready[0]), 128'(2'b01));
        nxt(); s_arvalid[0] = 1'b0;
        @(negedge clk);
        chkv("ar_bp_s1_m_ar", 128'(o_m_ar[0]), 128'(mk_ar(40'h400, 1)));
        chkv("ar_bp_s1_ready", 128'(o_arready[0]), 128'(2'b10));
        nxt(); s_arvalid[1] = 1'b0;

        // AR: stalled s1 grant must survive s0 arriving with pointer at s0
        s_ar[1] = mk_ar(40'h500, 1); s_arvalid[1] = 1'b1; m_arready = 1'b0;
        @(negedge clk);
        chkv("ar_hold_c0", 128'(o_m_ar[0]), 128'(mk_ar(40'h500, 1)));
        nxt(); s_ar[0] = mk_ar(40'h600, 0); s_arvalid[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chkv("ar_hold_m_ar", 128'(o_m_ar[0]), 128'(mk_ar(40'h500, 1)));
            nxt();
        end
        m_arready = 1'b1;
        @(negedge clk);
        chkv("ar_hold_rel_ready", 128'(o_arready[0]), 128'(2'b10));
        nxt(); s_arvalid[1] = 1'b0;
        @(negedge clk);
        chkv("ar_hold_s0_m_ar", 128'(o_m_ar[0]), 128'(mk_ar(40'h600, 0)));
        chkv("ar_hold_s0_ready", 128'(o_arready[0]), 128'(2'b01));
        nxt(); s_arvalid[0] = 1'b0;

        // Fixed priority instance: s0 always wins against continuous s1
        s_arvalid[0] = 1'b1; s_arvalid[1] = 1'b1; s_ar[1] = mk_ar(40'h800, 1);
        for (int i = 0; i < 6; i++) begin
            s_ar[0] = mk_ar(40'h700 + 40'(i), 0);
            @(negedge clk);
            chkv("fp_m_ar", 128'(o_m_ar[1]), 128'(mk_ar(40'h700 + 40'(i), 0)));
            chkv("fp_ready", 128'(o_arready[1]), 128'(2'b01));
            nxt();
        end
        clear_valids();

        // Write burst: s0 4 beats with toggling wready while s1 AW and W wait
        s_aw[0] = mk_aw(40'hA0, 0); s_aw[1] = mk_aw(40'hB0, 1);
        s_awvalid[0] = 1'b1; s_awvalid[1] = 1'b1;
        s_w[0] = mk_w(0, 1, 0, 1'b0); s_wvalid[0] = 1'b1;
        s_w[1] = mk_w(1, 1, 0, 1'b1); s_wvalid[1] = 1'b1;
        @(negedge clk);
        chkv("wr_aw_m_aw", 128'(o_m_aw[0]), 128'(mk_aw(40'hA0, 0)));
        chkv("wr_aw_ready", 128'(o_awready[0]), 128'(2'b01));
        chk1("wr_aw_bubble_wvalid", o_m_wvalid[0], 1'b0);
        chkv("wr_aw_bubble_wready", 128'(o_wready[0]), 128'(2'b00));
        chk1("wr_aw_busy", o_busy[0], 1'b0);
        nxt(); s_awvalid[0] = 1'b0;
        begin
            int b = 0;
            mwr = 1'b1;
            for (int c = 0; c < 7; c++) begin
                m_wready = mwr;
                s_w[0] = mk_w(0, 1, b, b == 3);
                @(negedge clk);
                chk1("wr_busy", o_busy[0], 1'b1);
                chk1("wr_m_wvalid", o_m_wvalid[0], 1'b1);
                chkv("wr_m_w", 128'(o_m_w[0]), 128'(mk_w(0, 1, b, b == 3)));
                chkv("wr_wready", 128'(o_wready[0]), 128'({1'b0, mwr}));
                chkv("wr_awready_locked", 128'(o_awready[0]), 128'(2'b00));
                chk1("wr_m_awvalid_locked", o_m_awvalid[0], 1'b0);
                chk1("wr_err", o_err[0], 1'b0);
                nxt();
                if (mwr) b++;
                mwr = !mwr;
            end
        end
        s_wvalid[0] = 1'b0; m_wready = 1'b1;
        @(negedge clk);
        chk1("wr_after_busy", o_busy[0], 1'b0);
        chk1("wr_exact_max_no_err", o_err[0], 1'b0);
        chkv("wr_s1_m_aw", 128'(o_m_aw[0]), 128'(mk_aw(40'hB0, 1)));
        chkv("wr_s1_awready", 128'(o_awready[0]), 128'(2'b10));
        nxt(); s_awvalid[1] = 1'b0;
        @(negedge clk);
        chkv("wr_s1_m_w", 128'(o_m_w[0]), 128'(mk_w(1, 1, 0, 1'b1)));
        chkv("wr_s1_wready", 128'(o_wready[0]), 128'(2'b10));
        nxt(); s_wvalid[1] = 1'b0;
        @(negedge clk);
        chk1("wr_s1_done", o_busy[0], 1'b0);

        // Over-length burst: 6 beats with MAX_WBEATS=4
        nxt();
        s_aw[0] = mk_aw(40'hC0, 0); s_awvalid[0] = 1'b1;
        @(negedge clk);
        chkv("len_aw_ready", 128'(o_awready[0]), 128'(2'b01));
        nxt(); s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b1;
        for (int b = 0; b < 6; b++) begin
            s_w[0] = mk_w(0, 2, b, b == 5);
            @(negedge clk);
            chkv("len_m_w", 128'(o_m_w[0]), 128'(mk_w(0, 2, b, b == 5)));
            chk1("len_busy", o_busy[0], 1'b1);
            chk1("len_err", o_err[0], b == 4);
            nxt();
        end
        s_wvalid[0] = 1'b0;
        @(negedge clk);
        chk1("len_idle", o_busy[0], 1'b0);
        chk1("len_err_after", o_err[0], 1'b0);

        // Reset during beat 2: wr_ptr (now s1) must return to s0
        nxt();
        s_aw[0] = mk_aw(40'hD0, 0); s_awvalid[0] = 1'b1;
        @(negedge clk);
        chkv("mid_aw_ready", 128'(o_awready[0]), 128'(2'b01));
        nxt(); s_awvalid[0] = 1'b0; s_wvalid[0] = 1'b1; s_w[0] = mk_w(0, 3, 0, 1'b0);
        @(negedge clk);
        chkv("mid_beat1", 128'(o_m_w[0]), 128'(mk_w(0, 3, 0, 1'b0)));
        nxt(); s_w[0] = mk_w(0, 3, 1, 1'b0); rst = 1'b1;
        @(negedge clk);
        chkv("mid_rst_readies", 128'({o_arready[0], o_awready[0], o_wready[0]}), 128'(0));
        chk1("mid_rst_wvalid", o_m_wvalid[0], 1'b0);
        nxt(); s_wvalid[0] = 1'b0;
        s_aw[0] = mk_aw(40'hE0, 0); s_aw[1] = mk_aw(40'hF0, 1);
        s_awvalid[0] = 1'b1; s_awvalid[1] = 1'b1;
        @(negedge clk);
        chk1("mid_rst_busy", o_busy[0], 1'b0);
        chkv("mid_rst_awready", 128'(o_awready[0]), 128'(2'b00));
        chk1("mid_rst_awvalid", o_m_awvalid[0], 1'b0);
        nxt(); rst = 1'b0;
        @(negedge clk);
        chkv("mid_post_m_aw", 128'(o_m_aw[0]), 128'(mk_aw(40'hE0, 0)));
        chkv("mid_post_awready", 128'(o_awready[0]), 128'(2'b01));
        nxt(); s_awvalid[0] = 1'b0; s_w[0] = mk_w(0, 4, 0, 1'b1); s_wvalid[0] = 1'b1;
        @(negedge clk);
        chkv("mid_post_m_w", 128'(o_m_w[0]), 128'(mk_w(0, 4, 0, 1'b1)));
        nxt(); s_wvalid[0] = 1'b0;
        @(negedge clk);
        chkv("mid_s1_awready", 128'(o_awready[0]), 128'(2'b10));
        nxt(); s_awvalid[1] = 1'b0; s_w[1] = mk_w(1, 4, 0, 1'b1); s_wvalid[1] = 1'b1;
        @(negedge clk);
        chkv("mid_s1_m_w", 128'(o_m_w[0]), 128'(mk_w(1, 4, 0, 1'b1)));
        nxt(); s_wvalid[1] = 1'b0;

        // Randomized traffic on instance 0 against the transaction model
        rst = 1'b1; clear_valids();
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        nxt(); nxt(); rst = 1'b0;
        ar_pref = 0; ar_hold = -1; aw_pref = 0; aw_hold = -1;
        busy = 0; owner = 0; nbeats = 0; err_exp = 1'b0;
        for (int s = 0; s < 2; s++) begin
            has_burst[s] = 0; bl_len[s] = 0; bl_sent[s] = 0; bl_id[s] = 16;
            drop_ar[s] = 1'b0; drop_aw[s] = 1'b0; drop_w[s] = 1'b0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            nxt();
            for (int s = 0; s < 2; s++) begin
                if (drop_ar[s]) s_arvalid[s] = 1'b0;
                if (drop_aw[s]) s_awvalid[s] = 1'b0;
                if (drop_w[s])  s_wvalid[s]  = 1'b0;
                drop_ar[s] = 1'b0; drop_aw[s] = 1'b0; drop_w[s] = 1'b0;
                if (!s_arvalid[s] && $urandom_range(0, 2) == 0) begin
                    s_ar[s] = mk_ar(40'($urandom()), s); s_arvalid[s] = 1'b1;
                end
                if (has_burst[s] == 0 && $urandom_range(0, 3) == 0) begin
                    has_burst[s] = 1; bl_len[s] = $urandom_range(1, 6); bl_sent[s] = 0; bl_id[s]++;
                    s_aw[s] = mk_aw(40'($urandom()), s); s_awvalid[s] = 1'b1;
                end
                if (has_burst[s] != 0 && !s_wvalid[s] && bl_sent[s] < bl_len[s] && $urandom_range(0, 1) == 1) begin
                    s_w[s] = mk_w(s, bl_id[s], bl_sent[s], bl_sent[s] == bl_len[s] - 1);
                    s_wvalid[s] = 1'b1;
                end
            end
            m_arready = ($urandom_range(0, 3) != 0);
            m_awready = ($urandom_range(0, 3) != 0);
            m_wready  = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            chk1("r_busy", o_busy[0], busy != 0);
            chk1("r_err", o_err[0], err_exp);

            e = pick(ar_hold, ar_pref, s_arvalid[0], s_arvalid[1]);
            chk1("r_m_arvalid", o_m_arvalid[0], e >= 0);
            if (e >= 0) chkv("r_m_ar", 128'(o_m_ar[0]), 128'(s_ar[e]));
            chkv("r_arready", 128'(o_arready[0]), 128'(rmask(e, m_arready)));
            if (e >= 0 && m_arready) begin
                ar_pref = 1 - e; ar_hold = -1; drop_ar[e] = 1'b1;
            end else begin
                ar_hold = e;
            end

            err_next = 1'b0;
            if (busy == 0) begin
                e = pick(aw_hold, aw_pref, s_awvalid[0], s_awvalid[1]);
                chk1("r_m_awvalid", o_m_awvalid[0], e >= 0);
                if (e >= 0) chkv("r_m_aw", 128'(o_m_aw[0]), 128'(s_aw[e]));
                chkv("r_awready", 128'(o_awready[0]), 128'(rmask(e, m_awready)));
                chk1("r_idle_wvalid", o_m_wvalid[0], 1'b0);
                chkv("r_idle_wready", 128'(o_wready[0]), 128'(2'b00));
                if (e >= 0 && m_awready) begin
                    busy = 1; owner = e; nbeats = 0; aw_hold = -1; drop_aw[e] = 1'b1;
                end else begin
                    aw_hold = e;
                end
            end else begin
                chk1("r_data_awvalid", o_m_awvalid[0], 1'b0);
                chkv("r_data_awready", 128'(o_awready[0]), 128'(2'b00));
                chk1("r_m_wvalid", o_m_wvalid[0], s_wvalid[owner]);
                if (s_wvalid[owner]) chkv("r_m_w", 128'(o_m_w[0]), 128'(s_w[owner]));
                chkv("r_wready", 128'(o_wready[0]), 128'(rmask(owner, m_wready)));
                if (s_wvalid[owner] && m_wready) begin
                    nbeats++; bl_sent[owner]++; drop_w[owner] = 1'b1;
                    if (s_w[owner].wlast) begin
                        busy = 0; aw_pref = 1 - owner; has_burst[owner] = 0;
                    end else if (nbeats == MAXB) begin
                        err_next = 1'b1;
                    end
                end
            end
            err_exp = err_next;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
